// File: rtl/slave_bus_pkg.sv
// Shared types and helpers for the serial-bus slaves: FSM states, mode encodings, header sizing.
package slave_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        WDATA,
        RPREF,
        RDATA
    } state_e;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    function automatic int hdr_bits(input int addr_width, input int len_width);
        return addr_width + len_width;
    endfunction

endpackage

// File: rtl/bram_sp.sv
// Single-port inferred BRAM, 1-cycle registered read, write-first; words beyond MEM_SIZE
// ignore writes and read back as zero.
module bram_sp #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_SIZE   = 4096
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [MEM_SIZE];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  in_range;

    assign in_range = 32'(addr_i) < MEM_SIZE;
    assign rdata_o  = rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i && in_range) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            if (!in_range) begin
                rdata_q <= '0;
            end else if (we_i) begin
                rdata_q <= wdata_i;
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

endmodule

// File: rtl/slave_bram_burst.sv
// Serial-bus burst slave in front of a single-port BRAM; reads stream without inter-beat gaps.
// SLAVE_BRAM_RANGE_ERR_EN adds a sticky serr flag for beats addressed beyond MEM_SIZE.
module slave_bram_burst
    import slave_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_SIZE   = 4096,
    parameter int LEN_WIDTH  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic swdata,
    output logic srdata,
    input  logic smode,
    input  logic mvalid,
    output logic svalid,
    output logic sready
`ifdef SLAVE_BRAM_RANGE_ERR_EN
    ,
    output logic serr
`endif
);

    localparam int HDR_BITS = hdr_bits(ADDR_WIDTH, LEN_WIDTH);
    localparam int CNT_W    = $clog2(HDR_BITS);
    localparam int BIT_W    = $clog2(DATA_WIDTH);

    state_e                state_q, state_d;
    logic                  mode_q, mode_d;
    logic [CNT_W-1:0]      hcnt_q, hcnt_d;
    logic [HDR_BITS-2:0]   hsr_q, hsr_d;
    logic [HDR_BITS-1:0]   hdr_full;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d, maddr_q, maddr_d, raddr;
    logic [LEN_WIDTH-1:0]  beat_q, beat_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_WIDTH-2:0] wsr_q, wsr_d;
    logic [DATA_WIDTH-1:0] wword, rsr_q, rsr_d, mwdata_q, mwdata_d, rdata;
    logic                  wen_q, wen_d, ren;
    logic                  srdata_q, srdata_d, svalid_q, svalid_d, rlast_q, rlast_d;

    // Shift registers hold only the bits already received; the live bit completes the word.
    assign hdr_full = {swdata, hsr_q};
    assign wword    = {swdata, wsr_q};

    assign srdata = srdata_q;
    assign svalid = svalid_q;
    assign sready = (state_q == IDLE);

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        hcnt_d   = hcnt_q;
        hsr_d    = hsr_q;
        ptr_d    = ptr_q;
        maddr_d  = maddr_q;
        beat_d   = beat_q;
        bit_d    = bit_q;
        wsr_d    = wsr_q;
        rsr_d    = rsr_q;
        mwdata_d = mwdata_q;
        wen_d    = 1'b0;
        ren      = 1'b0;
        raddr    = ptr_q;
        srdata_d = 1'b0;
        svalid_d = 1'b0;
        rlast_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (mvalid) begin
                    mode_d  = smode;
                    hsr_d   = hdr_full[HDR_BITS-1:1];
                    hcnt_d  = CNT_W'(1);
                    state_d = HDR;
                end
            end
            HDR: begin
                if (mvalid) begin
                    hsr_d = hdr_full[HDR_BITS-1:1];
                    if (hcnt_q == CNT_W'(HDR_BITS - 1)) begin
                        ptr_d   = hdr_full[ADDR_WIDTH-1:0];
                        beat_d  = hdr_full[HDR_BITS-1:ADDR_WIDTH];
                        hcnt_d  = '0;
                        bit_d   = '0;
                        state_d = (mode_q == MODE_WRITE) ? WDATA : RPREF;
                    end else begin
                        hcnt_d = hcnt_q + 1'b1;
                    end
                end
            end
            WDATA: begin
                if (mvalid) begin
                    wsr_d = wword[DATA_WIDTH-1:1];
                    if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
                        wen_d    = 1'b1;
                        maddr_d  = ptr_q;
                        mwdata_d = wword;
                        ptr_d    = ptr_q + 1'b1;
                        bit_d    = '0;
                        if (beat_q == '0) begin
                            state_d = IDLE;
                        end else begin
                            beat_d = beat_q - 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            RPREF: begin
                ren     = 1'b1;
                state_d = RDATA;
            end
            RDATA: begin
                if (rlast_q) begin
                    state_d = IDLE;
                end else begin
                    svalid_d = 1'b1;
                    if (bit_q == '0) begin
                        srdata_d = rdata[0];
                        rsr_d    = rdata >> 1;
                    end else begin
                        srdata_d = rsr_q[0];
                        rsr_d    = rsr_q >> 1;
                    end
                    // Prefetch one bit early so the next word is in rdata at the beat boundary.
                    if (bit_q == BIT_W'(DATA_WIDTH - 2) && beat_q != '0) begin
                        ren   = 1'b1;
                        raddr = ptr_q + 1'b1;
                        ptr_d = ptr_q + 1'b1;
                    end
                    if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
                        bit_d = '0;
                        if (beat_q == '0) begin
                            rlast_d = 1'b1;
                        end else begin
                            beat_d = beat_q - 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mode_q   <= 1'b0;
            hcnt_q   <= '0;
            hsr_q    <= '0;
            ptr_q    <= '0;
            maddr_q  <= '0;
            beat_q   <= '0;
            bit_q    <= '0;
            wsr_q    <= '0;
            rsr_q    <= '0;
            mwdata_q <= '0;
            wen_q    <= 1'b0;
            srdata_q <= 1'b0;
            svalid_q <= 1'b0;
            rlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            hcnt_q   <= hcnt_d;
            hsr_q    <= hsr_d;
            ptr_q    <= ptr_d;
            maddr_q  <= maddr_d;
            beat_q   <= beat_d;
            bit_q    <= bit_d;
            wsr_q    <= wsr_d;
            rsr_q    <= rsr_d;
            mwdata_q <= mwdata_d;
            wen_q    <= wen_d;
            srdata_q <= srdata_d;
            svalid_q <= svalid_d;
            rlast_q  <= rlast_d;
        end
    end

`ifdef SLAVE_BRAM_RANGE_ERR_EN
    logic serr_q, serr_d;

    always_comb begin
        serr_d = serr_q;
        if (state_q == IDLE && mvalid) begin
            serr_d = 1'b0;
        end
        if ((wen_d && 32'(maddr_d) >= MEM_SIZE) || (ren && 32'(raddr) >= MEM_SIZE)) begin
            serr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            serr_q <= 1'b0;
        end else begin
            serr_q <= serr_d;
        end
    end

    assign serr = serr_q;
`endif

    // Reads and writes never overlap in time, so the registered write owns the port when pending.
    bram_sp #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .MEM_SIZE  (MEM_SIZE)
    ) u_bram (
        .clk_i  (clk),
        .we_i   (wen_q),
        .re_i   (ren),
        .addr_i (wen_q ? maddr_q : raddr),
        .wdata_i(mwdata_q),
        .rdata_o(rdata)
    );

endmodule

// File: tb/tb_slave_bram_burst.sv
// Bench for slave_bram_burst: dut0 uses default MEM_SIZE, dut1 uses MEM_SIZE=3000; both share stimulus.
module tb_slave_bram_burst;
    import slave_bus_pkg::*;

    localparam int AW = 12;
    localparam int DW = 8;
    localparam int LW = 4;
    localparam int HB = AW + LW;

    logic clk = 1'b0;
    logic rst, swdata, smode, mvalid;
    logic srdata0, svalid0, sready0, srdata1, svalid1, sready1;
`ifdef SLAVE_BRAM_RANGE_ERR_EN
    logic serr0, serr1;
`endif

    int checks = 0;
    int errors = 0;
    int sel    = 0;
    logic [7:0] model [int];
    logic [7:0] exp_q [$];
    logic [7:0] wbuf  [16];

    always #5 clk = ~clk;

    slave_bram_burst #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_SIZE(4096), .LEN_WIDTH(LW)) dut0 (
        .clk(clk), .rst(rst), .swdata(swdata), .srdata(srdata0), .smode(smode),
        .mvalid(mvalid), .svalid(svalid0), .sready(sready0)
`ifdef SLAVE_BRAM_RANGE_ERR_EN
        , .serr(serr0)
`endif
    );

    slave_bram_burst #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_SIZE(3000), .LEN_WIDTH(LW)) dut1 (
        .clk(clk), .rst(rst), .swdata(swdata), .srdata(srdata1), .smode(smode),
        .mvalid(mvalid), .svalid(svalid1), .sready(sready1)
`ifdef SLAVE_BRAM_RANGE_ERR_EN
        , .serr(serr1)
`endif
    );

    function automatic logic o_srdata();
        return (sel == 1) ? srdata1 : srdata0;
    endfunction
    function automatic logic o_svalid();
        return (sel == 1) ? svalid1 : svalid0;
    endfunction
    function automatic logic o_sready();
        return (sel == 1) ? sready1 : sready0;
    endfunction

    task automatic idle_bus();
        mvalid = 1'b0;
        swdata = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        swdata = b;
        mvalid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_hdr(input logic mode, input logic [AW-1:0] a, input logic [LW-1:0] len);
        logic [HB-1:0] h;
        h = {len, a};
        smode = mode ? MODE_WRITE : MODE_READ;
        for (int i = 0; i < HB; i++) begin
            send_bit(h[i]);
            if (i == 0) begin
                checks++;
                if (o_sready() !== 1'b0) begin
                    errors++;
                    $display("FAIL hdr_sready: got %b, expected 0", o_sready());
                end
            end
        end
        idle_bus();
    endtask

    task automatic write_burst(input logic [AW-1:0] a, input int len,
                               input int stall_beat, input int stall_bit, input int stall_n);
        send_hdr(1'b1, a, LW'(len));
        for (int b = 0; b <= len; b++) begin
            for (int i = 0; i < DW; i++) begin
                if (b == stall_beat && i == stall_bit) begin
                    idle_bus();
                    repeat (stall_n) @(posedge clk);
                    #1;
                end
                send_bit(wbuf[b][i]);
            end
            model[(int'(a) + b) % 4096] = wbuf[b];
        end
        idle_bus();
        checks++;
        if (o_sready() !== 1'b1) begin
            errors++;
            $display("FAIL wr_done_sready: got %b, expected 1", o_sready());
        end
    endtask

    task automatic read_burst(input logic [AW-1:0] a, input int len);
        int msize, lat, gaps, ad;
        logic [7:0] word, expv;
        msize = (sel == 1) ? 3000 : 4096;
        for (int b = 0; b <= len; b++) begin
            ad = (int'(a) + b) % 4096;
            exp_q.push_back((ad < msize) ? model[ad] : 8'h00);
        end
        send_hdr(1'b0, a, LW'(len));
        // svalid must rise on the second clock edge after the one sampling the last header bit
        lat = 0;
        while (o_svalid() !== 1'b1 && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat != 2) begin
            errors++;
            $display("FAIL rd_latency: got %0d cycles, expected 2", lat);
        end
        if (lat >= 10) begin
            exp_q.delete();
            return;
        end
        gaps = 0;
        for (int b = 0; b <= len; b++) begin
            for (int i = 0; i < DW; i++) begin
                if (!(b == 0 && i == 0)) begin
                    @(posedge clk);
                    #1;
                end
                if (o_svalid() !== 1'b1) gaps++;
                word[i] = o_srdata();
            end
            expv = exp_q.pop_front();
            checks++;
            if (word !== expv) begin
                errors++;
                $display("FAIL rd_data: beat %0d got %h, expected %h", b, word, expv);
            end
        end
        checks++;
        if (gaps != 0) begin
            errors++;
            $display("FAIL svalid_continuous: got %0d gap cycles, expected 0", gaps);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({o_svalid(), o_srdata(), o_sready()} !== 3'b001) begin
            errors++;
            $display("FAIL rd_end: got svalid/srdata/sready %b%b%b, expected 001",
                     o_svalid(), o_srdata(), o_sready());
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({srdata0, svalid0, sready0} !== 3'b001) begin
            errors++;
            $display("FAIL reset_outputs: got srdata/svalid/sready %b%b%b, expected 001",
                     srdata0, svalid0, sready0);
        end
    endtask

    task automatic test_single();
        wbuf[0] = 8'hA5;
        write_burst(12'h010, 0, -1, 0, 0);
        read_burst(12'h010, 0);
    endtask

    task automatic test_burst();
        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
        write_burst(12'h100, 3, -1, 0, 0);
        read_burst(12'h100, 3);
    endtask

    task automatic test_wrap_stall();
        wbuf[0] = 8'h01; wbuf[1] = 8'h02; wbuf[2] = 8'h03; wbuf[3] = 8'h04;
        write_burst(12'hFFE, 3, 2, 3, 5);
        read_burst(12'hFFE, 1);
        read_burst(12'h000, 1);
        read_burst(12'hFFE, 3);
    endtask

    task automatic test_out_of_range();
        sel = 1;
        wbuf[0] = 8'hBB;
        write_burst(12'd3000, 0, -1, 0, 0);
`ifdef SLAVE_BRAM_RANGE_ERR_EN
        checks++;
        if (serr1 !== 1'b1) begin
            errors++;
            $display("FAIL serr_set: got %b, expected 1", serr1);
        end
`endif
        wbuf[0] = 8'h5A;
        write_burst(12'h005, 0, -1, 0, 0);
`ifdef SLAVE_BRAM_RANGE_ERR_EN
        checks++;
        if (serr1 !== 1'b0) begin
            errors++;
            $display("FAIL serr_clear: got %b, expected 0", serr1);
        end
`endif
        read_burst(12'd3000, 0);
        read_burst(12'h005, 0);
        sel = 0;
        read_burst(12'd3000, 0);
    endtask

    task automatic test_reset_mid();
        wbuf[0] = 8'h00; wbuf[1] = 8'h77;
        write_burst(12'h200, 1, -1, 0, 0);
        send_hdr(1'b1, 12'h200, 4'd3);
        wbuf[0] = 8'hC1; wbuf[1] = 8'hC2;
        for (int i = 0; i < DW; i++) send_bit(wbuf[0][i]);
        model[12'h200] = 8'hC1;
        for (int i = 0; i < 4; i++) send_bit(wbuf[1][i]);
        idle_bus();
        rst = 1'b1;
        #1;
        checks++;
        if ({sready0, svalid0} !== 2'b10) begin
            errors++;
            $display("FAIL rst_abort: got sready/svalid %b%b, expected 10", sready0, svalid0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        read_burst(12'h200, 1);
    endtask

    task automatic test_max_burst();
        for (int i = 0; i < 16; i++) wbuf[i] = 8'h30 + 8'(i * 7);
        write_burst(12'h000, 15, -1, 0, 0);
        read_burst(12'h000, 15);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        smode = 1'b0;
        idle_bus();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        test_single();
        test_burst();
        test_wrap_stall();
        test_out_of_range();
        test_reset_mid();
        test_max_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
